// File: rtl/instr_fetch_seq.sv
// ============================================================================
// Module   : instr_fetch_seq
// Brief    : Builds 16-bit instructions from a byte-wide instruction memory
//            (high byte first) and delivers them over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_seq #(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter bit                HALT_ON_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam logic [1:0] FETCH_HI = 2'd0;
    localparam logic [1:0] FETCH_LO = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] HALT     = 2'd3;

    localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_two = ADDR_W'(2);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_hi_byte;
    logic [15:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_valid;
    logic              r_halted;
    logic              w_handshake;

    assign w_handshake = r_valid & instr_ready;

    // Only the low-byte fetch looks past pc; every other state parks on pc.
    assign mem_addr    = (r_state == FETCH_LO) ? (r_pc + c_one) : r_pc;

    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH_HI;
            r_pc       <= RESET_PC;
            r_hi_byte  <= 8'h00;
            r_instr    <= 16'h0000;
            r_instr_pc <= RESET_PC;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else if (redirect) begin
            // A same-cycle handshake still completes; the held instruction is
            // simply retired and fetch restarts at the target without halting.
            r_pc     <= redirect_pc;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_state  <= FETCH_HI;
        end else begin
            case (r_state)
                FETCH_HI: begin
                    r_hi_byte <= mem_data;
                    r_state   <= FETCH_LO;
                end
                FETCH_LO: begin
                    r_instr    <= {r_hi_byte, mem_data};
                    r_instr_pc <= r_pc;
                    r_valid    <= 1'b1;
                    r_pc       <= r_pc + c_two;
                    r_state    <= HOLD;
                end
                HOLD: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (HALT_ON_ZERO && (r_instr == 16'h0000)) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else begin
                            r_state  <= FETCH_HI;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= FETCH_HI;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
// ============================================================================
// Module   : tb_instr_fetch_seq
// Brief    : Self-checking bench for instr_fetch_seq: directed scenarios plus
//            randomized traffic against a cycle-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        halted;

    logic [7:0]  mem [256];
    int          errors = 0;
    int          checks = 0;

    // Reference model: fetch countdown, expected pc and the pending instruction
    int          m_cnt;
    logic [7:0]  m_pc;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_instr;
    logic [7:0]  m_ipc;

    assign mem_data = mem[mem_addr];

    always #5 clk = ~clk;

    instr_fetch_seq #(
        .ADDR_W      (8),
        .RESET_PC    (8'h00),
        .HALT_ON_ZERO(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    function automatic logic [7:0] exp_addr();
        logic [7:0] a;
        a = m_pc;
        if (!m_valid && !m_halted && m_cnt == 1) a = m_pc + 8'd1;
        return a;
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_cnt = 2; m_valid = 1'b0; m_halted = 1'b0;
        m_instr = 16'h0000; m_ipc = 8'h00;
    endtask

    // Applies inputs at a falling edge, advances the model across the next
    // rising edge, and returns at the following falling edge.
    task automatic tick(input logic rdy, input logic rd, input logic [7:0] rpc);
        logic [7:0] nxt;
        instr_ready = rdy; redirect = rd; redirect_pc = rpc;
        if (rd) begin
            m_pc = rpc; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 2;
        end else if (m_halted) begin
            m_cnt = 0;
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 1'b0;
                if (m_instr == 16'h0000) m_halted = 1'b1;
                else m_cnt = 2;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                nxt = m_pc + 8'd1;
                m_instr = {mem[m_pc], mem[nxt]};
                m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 8'd2;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || halted !== 1'b0 || mem_addr !== 8'h00 ||
            instr !== 16'h0000 || instr_pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: valid=%b halted=%b addr=%h instr=%h ipc=%h, need 0/0/00/0000/00",
                     instr_valid, halted, mem_addr, instr, instr_pc);
        end
        do_reset();
    endtask

    task automatic test_stream();
        int gap;
        do_reset();
        checks++;
        if (mem_addr !== 8'h00) begin errors++; $display("FAIL stream_addr0: got %h need 00", mem_addr); end
        tick(1, 0, 0);
        checks++;
        if (mem_addr !== 8'h01 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL stream_addr1: addr=%h valid=%b need 01/0", mem_addr, instr_valid);
        end
        tick(1, 0, 0);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h0345 || instr_pc !== 8'h00) begin
            errors++; $display("FAIL stream_first: valid=%b instr=%h ipc=%h need 1/0345/00", instr_valid, instr, instr_pc);
        end
        gap = 0;
        do begin
            tick(1, 0, 0);
            gap++;
        end while (!instr_valid && gap < 10);
        checks++;
        if (gap !== 3 || instr !== 16'h0465 || instr_pc !== 8'h02) begin
            errors++; $display("FAIL stream_second: gap=%0d instr=%h ipc=%h need 3/0465/02", gap, instr, instr_pc);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(0, 0, 0);
        tick(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0);
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'h0345 || mem_addr !== 8'h02) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b instr=%h addr=%h need 1/0345/02", i, instr_valid, instr, mem_addr);
            end
        end
        tick(1, 0, 0);
        checks++;
        if (instr_valid !== 1'b0 || mem_addr !== 8'h02) begin
            errors++; $display("FAIL bp_release: valid=%b addr=%h need 0/02", instr_valid, mem_addr);
        end
        tick(1, 0, 0);
        checks++;
        if (mem_addr !== 8'h03) begin errors++; $display("FAIL bp_next_fetch: addr=%h need 03", mem_addr); end
    endtask

    task automatic test_halt();
        int bad;
        tick(1, 1, 8'd10);
        tick(1, 0, 0);
        tick(0, 0, 0);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h0000 || instr_pc !== 8'd10) begin
            errors++; $display("FAIL halt_zero_instr: valid=%b instr=%h ipc=%h need 1/0000/0a", instr_valid, instr, instr_pc);
        end
        bad = 0;
        for (int i = 0; i < 21; i++) begin
            tick(1, 0, 0);
            if (halted !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 8'd12) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL halt_stay: bad_cycles=%0d need 0", bad); end
        tick(1, 1, 8'd12);
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit: halted=%b need 0", halted); end
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h07D5 || instr_pc !== 8'd12) begin
            errors++; $display("FAIL halt_resume: valid=%b instr=%h ipc=%h need 1/07d5/0c", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_redirect_lo();
        do_reset();
        tick(1, 1, 8'd4);
        tick(1, 0, 0);
        checks++;
        if (mem_addr !== 8'd5) begin errors++; $display("FAIL redir_lo_addr: addr=%h need 05", mem_addr); end
        tick(1, 1, 8'd8);
        checks++;
        if (instr_valid !== 1'b0 || mem_addr !== 8'd8) begin
            errors++; $display("FAIL redir_lo_discard: valid=%b addr=%h need 0/08", instr_valid, mem_addr);
        end
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h07D6 || instr_pc !== 8'd8) begin
            errors++; $display("FAIL redir_lo_target: valid=%b instr=%h ipc=%h need 1/07d6/08", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_wrap();
        tick(1, 1, 8'hFE);
        checks++;
        if (mem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_fe_hi: addr=%h need fe", mem_addr); end
        tick(1, 0, 0);
        checks++;
        if (mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_fe_lo: addr=%h need ff", mem_addr); end
        tick(1, 0, 0);
        checks++;
        if (instr_pc !== 8'hFE || instr !== 16'h1234 || mem_addr !== 8'h00) begin
            errors++; $display("FAIL wrap_fe_done: ipc=%h instr=%h addr=%h need fe/1234/00", instr_pc, instr, mem_addr);
        end
        tick(1, 1, 8'hFF);
        tick(1, 0, 0);
        checks++;
        if (mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_ff_lo: addr=%h need 00", mem_addr); end
        tick(0, 0, 0);
        checks++;
        if (instr_pc !== 8'hFF || instr !== 16'h3403 || mem_addr !== 8'h01) begin
            errors++; $display("FAIL wrap_ff_done: ipc=%h instr=%h addr=%h need ff/3403/01", instr_pc, instr, mem_addr);
        end
    endtask

    task automatic test_async_reset();
        tick(0, 1, 8'd8);
        tick(0, 0, 0);
        tick(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || mem_addr !== 8'h00) begin
            errors++; $display("FAIL async_reset: valid=%b addr=%h need 0/00", instr_valid, mem_addr);
        end
        do_reset();
    endtask

    task automatic test_redirect_handshake_zero();
        tick(1, 1, 8'd10);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 1, 8'd12);
        checks++;
        if (halted !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 8'd12) begin
            errors++; $display("FAIL redir_hs_zero: halted=%b valid=%b addr=%h need 0/0/0c", halted, instr_valid, mem_addr);
        end
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++;
        if (instr !== 16'h07D5 || instr_pc !== 8'd12) begin
            errors++; $display("FAIL redir_hs_resume: instr=%h ipc=%h need 07d5/0c", instr, instr_pc);
        end
    endtask

    task automatic test_random();
        int bad_ctl, bad_data, seen;
        logic rdy, rd;
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        do_reset();
        bad_ctl = 0; bad_data = 0; seen = 0;
        for (int c = 0; c < 3000; c++) begin
            if (instr_valid !== m_valid || halted !== m_halted || mem_addr !== exp_addr()) begin
                bad_ctl++;
                if (bad_ctl < 5) $display("FAIL rand_ctl@%0d: valid=%b halted=%b addr=%h need %b/%b/%h",
                                          c, instr_valid, halted, mem_addr, m_valid, m_halted, exp_addr());
            end
            if (m_valid) begin
                seen++;
                if (instr !== m_instr || instr_pc !== m_ipc) begin
                    bad_data++;
                    if (bad_data < 5) $display("FAIL rand_data@%0d: instr=%h ipc=%h need %h/%h",
                                               c, instr, instr_pc, m_instr, m_ipc);
                end
            end
            rdy = ($urandom_range(0, 1) == 1);
            rd  = ($urandom_range(0, 99) < (m_halted ? 30 : 4));
            tick(rdy, rd, 8'($urandom));
        end
        checks++;
        if (bad_ctl != 0) begin errors++; $display("FAIL rand_control: bad_cycles=%0d need 0", bad_ctl); end
        checks++;
        if (bad_data != 0 || seen == 0) begin
            errors++; $display("FAIL rand_instr: bad=%0d seen=%0d need 0/>0", bad_data, seen);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
        mem[0] = 8'h03; mem[1] = 8'h45; mem[2] = 8'h04; mem[3] = 8'h65;
        mem[8] = 8'h07; mem[9] = 8'hD6; mem[10] = 8'h00; mem[11] = 8'h00;
        mem[12] = 8'h07; mem[13] = 8'hD5;
        mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_halt();
        test_redirect_lo();
        test_wrap();
        test_async_reset();
        test_redirect_handshake_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
